// File: rtl/traffic_light_fsm_pkg.sv
// traffic_pkg: shared state encodings and light constants for the intersection controller
package traffic_pkg;
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic logic [5:0] lights_of(state_e s);
        return {s == MAIN_GREEN ? LIGHT_GREEN : s == MAIN_YELLOW ? LIGHT_YELLOW : LIGHT_RED,
                s == SIDE_GREEN ? LIGHT_GREEN : s == SIDE_YELLOW ? LIGHT_YELLOW : LIGHT_RED};
    endfunction
endpackage

// File: rtl/traffic_light_fsm_timer.sv
// phase_timer: tick counter with clear, saturating hold at the final count and an expiry flag
module phase_timer #(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_i,
    input  logic              clear_i,
    input  logic              hold_i,
    input  logic [TICK_W-1:0] dur_i,
    output logic              expired_o
);
    logic [TICK_W-1:0] count_q, count_d;
    logic              at_end;

    assign at_end    = count_q == dur_i - TICK_W'(1);
    assign expired_o = tick_i && at_end && !hold_i;

    always_comb begin
        count_d = clear_i ? '0 : !tick_i ? count_q : !at_end ? count_q + TICK_W'(1) : hold_i ? count_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road phase controller timed by divider ticks, with latched side requests
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int                TICK_W         = 8,
    parameter logic [TICK_W-1:0] MAIN_GREEN_MIN = TICK_W'(10),
    parameter logic [TICK_W-1:0] MAIN_YELLOW_T  = TICK_W'(3),
    parameter logic [TICK_W-1:0] ALL_RED_T      = TICK_W'(1),
    parameter logic [TICK_W-1:0] SIDE_GREEN_T   = TICK_W'(6),
    parameter logic [TICK_W-1:0] SIDE_YELLOW_T  = TICK_W'(3)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_input,
    input  logic       side_request,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       divider_reset,
    output logic [2:0] phase
);
    state_e            state_q, state_d;
    logic              req_pending_q, req_pending_d;
    logic              div_rst_q, div_rst_d;
    logic [2:0]        main_q, side_q;
    logic [TICK_W-1:0] dur;
    logic              illegal, hold, expired;

    phase_timer #(.TICK_W(TICK_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (enable_input),
        .clear_i  (illegal),
        .hold_i   (hold),
        .dur_i    (dur),
        .expired_o(expired)
    );

    always_comb begin
        illegal = 3'(state_q) > 3'd5;
        hold    = state_q == MAIN_GREEN && !req_pending_q;
        dur     = state_q == MAIN_GREEN  ? MAIN_GREEN_MIN :
                  state_q == MAIN_YELLOW ? MAIN_YELLOW_T  :
                  state_q == SIDE_GREEN  ? SIDE_GREEN_T   :
                  state_q == SIDE_YELLOW ? SIDE_YELLOW_T  : ALL_RED_T;
        state_d = illegal                  ? MAIN_GREEN  :
                  !expired                 ? state_q     :
                  state_q == MAIN_GREEN    ? MAIN_YELLOW :
                  state_q == MAIN_YELLOW   ? ALL_RED_A   :
                  state_q == ALL_RED_A     ? SIDE_GREEN  :
                  state_q == SIDE_GREEN    ? SIDE_YELLOW :
                  state_q == SIDE_YELLOW   ? ALL_RED_B   : MAIN_GREEN;
        // a request arriving in the SIDE_GREEN entry cycle survives for the next cycle
        req_pending_d = side_request || (req_pending_q && !(state_d == SIDE_GREEN && state_q != SIDE_GREEN));
        div_rst_d     = state_d != state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MAIN_GREEN;
            req_pending_q <= 1'b0;
            div_rst_q     <= 1'b1;
            main_q        <= LIGHT_GREEN;
            side_q        <= LIGHT_RED;
        end else begin
            state_q          <= state_d;
            req_pending_q    <= req_pending_d;
            div_rst_q        <= div_rst_d;
            {main_q, side_q} <= lights_of(state_d);
        end
    end

    assign main_lights   = main_q;
    assign side_lights   = side_q;
    assign divider_reset = div_rst_q;
    assign phase         = 3'(state_q);
endmodule
